dm_unloader: RTL

DM_UNLOADER -- requirements
Module: dm_unloader

---
 rtl/dm_unloader_pkg.sv | 17 +
 rtl/dm_unloader.sv | 104 ++++++++++
 2 files changed

// File: rtl/dm_unloader_pkg.sv
// DM unloader shared definitions.
// State encoding and default widths.
package dm_unloader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    FIN   = 2'd3
  } state_e;

  localparam int DATA_SIZE_DEF     = 32;
  localparam int DM_ADDR_SIZE_DEF  = 15;
  localparam int MEM_ADDR_SIZE_DEF = 14;
  localparam int LEN_W             = 14;

endpackage

// File: rtl/dm_unloader.sv
// DM-to-MEM block copier.
// One READ/WRITE pair per word, then a FIN cycle.
module dm_unloader
  import dm_unloader_pkg::*;
#(
  parameter int DataSize    = DATA_SIZE_DEF,
  parameter int DMAddrSize  = DM_ADDR_SIZE_DEF,
  parameter int MEMAddrSize = MEM_ADDR_SIZE_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DMAddrSize-1:0]  dm_base,
  input  logic [MEMAddrSize-1:0] mem_base,
  input  logic [LEN_W-1:0]       length,
  output logic                   busy,
  output logic                   done,
  output logic [LEN_W-1:0]       word_cnt,
  output logic                   DM_enable,
  output logic                   DM_read,
  output logic [DMAddrSize-1:0]  DM_address,
  input  logic [DataSize-1:0]    DM_out,
  output logic                   MEM_en,
  output logic                   MEM_write,
  output logic                   MEM_read,
  output logic [MEMAddrSize-1:0] MEM_addr,
  output logic [DataSize-1:0]    MEM_din
);

  state_e                 state_q, state_d;
  logic [DMAddrSize-1:0]  dm_base_q;
  logic [MEMAddrSize-1:0] mem_base_q;
  logic [LEN_W-1:0]       len_q;
  logic [LEN_W-1:0]       cnt_q;
  logic                   accept;
  logic                   last;

  assign accept = (state_q == IDLE) && start;
  assign last   = (cnt_q + LEN_W'(1)) == len_q;

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (length != '0) ? READ : FIN;
        end
      end
      READ:  state_d = WRITE;
      WRITE: state_d = last ? FIN : READ;
      FIN:   state_d = IDLE;
    endcase
  end

  // State, captured operands and word counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      dm_base_q  <= '0;
      mem_base_q <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        dm_base_q  <= dm_base;
        mem_base_q <= mem_base;
        len_q      <= length;
        cnt_q      <= '0;
      end else if (state_q == WRITE) begin
        cnt_q <= cnt_q + LEN_W'(1);
      end
    end
  end

  // Strobes and addresses decoded from state only.
  always_comb begin
    busy       = (state_q != IDLE);
    done       = (state_q == FIN);
    DM_enable  = 1'b0;
    DM_read    = 1'b0;
    DM_address = '0;
    MEM_en     = 1'b0;
    MEM_write  = 1'b0;
    MEM_read   = 1'b0;
    MEM_addr   = '0;
    MEM_din    = '0;
    if (state_q == READ) begin
      DM_enable  = 1'b1;
      DM_read    = 1'b1;
      DM_address = dm_base_q + DMAddrSize'(cnt_q);
    end
    if (state_q == WRITE) begin
      MEM_en    = 1'b1;
      MEM_write = 1'b1;
      MEM_addr  = mem_base_q + MEMAddrSize'(cnt_q);
      MEM_din   = DM_out;
    end
  end

  assign word_cnt = cnt_q;

endmodule
